mpu_issue: RTL and testbench
============================

# mpu_issue

Microprogram issue sequencer for the MPU: the producer side of the 18-bit instruction interface consumed by the `mpc` decoder. A host loads up to 16 instruction words into a local buffer, then starts a run. The block issues the words in order over a valid/ready handshake, optionally repeating the program a programmed number of times, and pulses `done` at the end.

## Interface
- `INSTR_W`, default 18: instruction width; matches the decoder `instr` input.
- `DEPTH`, default 16: buffer entries.
- `ADDR_W`, default 4: log2(`DEPTH`).

- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: synchronous, active-low reset.
- `wr_en` in, 1: buffer write strobe.
- `wr_addr` in, `ADDR_W`: buffer write address.
- `wr_data` in, `INSTR_W`: buffer write data.
- `start` in, 1: begin run; sampled only in IDLE.
- `len` in, `ADDR_W+1`: program length, 0..16; sampled on accepted `start`.
- `loop_cnt` in, 8: extra repetitions, 0..255; sampled on accepted `start`.
- `instr_valid` out, 1: `instr` holds a word to issue.
- `instr_ready` in, 1: decoder accepts the word.
- `instr` out, `INSTR_W`: instruction word to the decoder.
- `pc` out, `ADDR_W`: index of the current word.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse at the end of a run.

## Operation
- FSM has three states:
  - IDLE → ISSUE on `start` with `len`≠0.
  - IDLE → DONE on `start` with `len`==0. No word is issued.
  - ISSUE → DONE on the final handshake.
  - DONE → IDLE unconditionally.
- On an accepted `start`:
  - Latch `len` and `loop_cnt`.
  - Clear `pc` and the iteration counter `iter` (8-bit).
- ISSUE state:
  - `instr_valid`=1.
  - `instr` = buf[`pc`], a combinational read of the registered buffer.
- Handshake = `instr_valid` & `instr_ready`. On each handshake:
  - If `pc` ≠ `len`-1: `pc`++.
  - Else if `iter` ≠ `loop_cnt`: `pc`←0 and `iter`++. This wraps the program.
  - Else: go to DONE.
- Total words issued = `len` × (`loop_cnt`+1).
- `instr` and `pc` stay stable while `instr_valid`=1 and `instr_ready`=0. `instr_valid` never drops without a handshake.
- `done`=1 only in DONE.
- Outputs outside ISSUE: `instr`=0 and `instr_valid`=0.
- Buffer writes:
  - Honoured only in IDLE. Writes in ISSUE or DONE are dropped.
  - A write in the same cycle as an accepted `start` is honoured and visible at the first issue.
- `start` in ISSUE or DONE is ignored.

## Timing
- Reset values (sync, `rst_n`=0 at a clock edge):
  - state=IDLE.
  - `instr_valid`=0, `instr`=0, `pc`=0, `busy`=0, `done`=0, `iter`=0.
  - Buffer contents are NOT cleared.
- Reset mid-run aborts immediately. No `done` pulse. The next run needs a fresh `start`.
- `start` at edge N:
  - `instr_valid`=1 and `busy`=1 from cycle N+1.
  - Back-to-back handshakes issue one word per cycle. There are no bubbles, including at loop wrap.
- Final handshake at edge M: `done`=1 in cycle M+1; back in IDLE at M+2.
- `len`==0 start at edge N: `done`=1 in cycle N+1; `busy`=1 in cycle N+1 only.
- `len` > 16 saturates to 16.

## Configuration
- `MPU_ISSUE_NOP_SKIP_EN` defined: all-zero buffer words are NOPs.
  - When buf[`pc`]==0 in ISSUE, `instr_valid` is 0 for that cycle.
  - `pc`/`iter` advance as if a handshake occurred, one cycle per NOP.
  - A program consisting only of NOPs still ends with a `done` pulse.
- Macro undefined: zero words are issued like any other word.

## Structure
- Shared package `mpu_pkg`:
  - `INSTR_W`=18 and the decoder output width 9.
  - FSM state encodings IDLE/ISSUE/DONE.
  - The all-zero NOP constant.
- One sub-module, `mpu_issue_buf`: `DEPTH`×`INSTR_W` register file with one synchronous write port and one combinational read port.
- Sequencer FSM, `pc`, and `iter` live in the top.

## Test plan
- Load buf[0]=18'b000000011100000001, buf[1]=18'h00123. Start `len`=2, `loop_cnt`=0 with `instr_ready`=1. Required:
  - `instr` = 0x00701, then 0x00123, on consecutive cycles.
  - `done` one cycle after the last word.
- `len`=3, `loop_cnt`=2, `instr_ready`=1 → nine words in 9 cycles, order 0,1,2,0,1,2,0,1,2. No gap at the wrap.
- Hold `instr_ready`=0 for 5 cycles mid-run → `instr`/`pc` frozen, `instr_valid` held at 1; issue resumes on the same word.
- `start` with `len`=0 → no `instr_valid`; `done`=1 exactly one cycle later.
- Write buf[0]=0x3FFFF during ISSUE, then rerun → old buf[0] value issued. Pulse `rst_n`=0 mid-run → all outputs 0 next cycle, no `done`.
- With `MPU_ISSUE_NOP_SKIP_EN`: program {0x00005, 0, 0x00007}, `len`=3 → two handshakes (0x00005, 0x00007), with one invalid cycle between them.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared MPU definitions: instruction/decoder widths, issue FSM encodings, NOP word.
// Pure declarations; no timing or flow control of its own.
package mpu_pkg;

    localparam int INSTR_W   = 18;
    localparam int DEC_OUT_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } issue_state_e;

    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/mpu_issue_buf.sv
// Program buffer: DEPTH x INSTR_W regfile, one synchronous write and one combinational read.
// Write lands at the clock edge, read is same-cycle; no backpressure, contents are never reset.
module mpu_issue_buf
    import mpu_pkg::*;
#(
    parameter int INSTR_W = mpu_pkg::INSTR_W,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mpu_issue.sv
// Issue sequencer: plays len words from the buffer (loop_cnt+1 times) to the decoder, then pulses done.
// First word valid the cycle after start, one word per cycle; holds word while instr_ready=0 (MPU_ISSUE_NOP_SKIP_EN skips zero words).
module mpu_issue
    import mpu_pkg::*;
#(
    parameter int INSTR_W = mpu_pkg::INSTR_W,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               start,
    input  logic [ADDR_W:0]    len,
    input  logic [7:0]         loop_cnt,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    issue_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [7:0]         iter_q, iter_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [7:0]         loop_q, loop_d;

    logic [INSTR_W-1:0] rd_word;
    logic               buf_we;
    logic               last_word;
    logic               advance;

    // Loading is only allowed while idle so a running program can't be altered underneath itself.
    assign buf_we = wr_en && (state_q == ST_IDLE);

    mpu_issue_buf #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc_q),
        .rd_data (rd_word)
    );

    assign last_word = ({1'b0, pc_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        iter_d      = iter_q;
        len_d       = len_q;
        loop_d      = loop_q;
        instr_valid = 1'b0;
        instr       = '0;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                    loop_d  = loop_cnt;
                    pc_d    = '0;
                    iter_d  = '0;
                    state_d = (len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr = rd_word;
`ifdef MPU_ISSUE_NOP_SKIP_EN
                // A NOP is consumed locally in one cycle without presenting it to the decoder.
                instr_valid = (rd_word != INSTR_W'(NOP_WORD));
                advance     = (instr_valid && instr_ready) || !instr_valid;
`else
                instr_valid = 1'b1;
                advance     = instr_ready;
`endif
                if (advance) begin
                    if (!last_word) begin
                        pc_d = pc_q + PC_ONE;
                    end else if (iter_q != loop_q) begin
                        pc_d   = '0;
                        iter_d = iter_q + 8'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            iter_q  <= '0;
            len_q   <= '0;
            loop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iter_q  <= iter_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
        end
    end

    assign pc   = pc_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mpu_issue.sv
// Directed bench for mpu_issue: hand-computed expectations checked by immediate assertions.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_mpu_issue;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [17:0] wr_data;
    logic        start;
    logic [4:0]  len;
    logic [7:0]  loop_cnt;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    mpu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .len         (len),
        .loop_cnt    (loop_cnt),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [17:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic go(input logic [4:0] l, input logic [7:0] lc);
        len      = l;
        loop_cnt = lc;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        logic [17:0] prog3 [3];
        prog3[0] = 18'h00701;
        prog3[1] = 18'h00123;
        prog3[2] = 18'h00ABC;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0; loop_cnt = '0; instr_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc",    32'(pc), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        wr(4'd0, 18'b000000011100000001);
        wr(4'd1, 18'h00123);
        wr(4'd2, 18'h00ABC);
        for (int i = 3; i < 16; i++) wr(4'(i), 18'(32'h100 + i));

        // two-word program, single pass
        instr_ready = 1'b1;
        go(5'd2, 8'd0);
        chk("t1_valid0", 32'(instr_valid), 32'd1);
        chk("t1_busy0",  32'(busy), 32'd1);
        chk("t1_instr0", 32'(instr), 32'h00701);
        chk("t1_pc0",    32'(pc), 32'd0);
        tick();
        chk("t1_instr1", 32'(instr), 32'h00123);
        chk("t1_pc1",    32'(pc), 32'd1);
        tick();
        chk("t1_done",   32'(done), 32'd1);
        chk("t1_dvalid", 32'(instr_valid), 32'd0);
        chk("t1_dinstr", 32'(instr), 32'd0);
        chk("t1_dbusy",  32'(busy), 32'd1);
        tick();
        chk("t1_idle_done", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // three-word program played three times, no bubble at the wrap
        go(5'd3, 8'd2);
        for (int k = 0; k < 9; k++) begin
            chk("t2_valid", 32'(instr_valid), 32'd1);
            chk("t2_instr", 32'(instr), 32'(prog3[k % 3]));
            chk("t2_pc",    32'(pc), 32'(k % 3));
            tick();
        end
        chk("t2_done", 32'(done), 32'd1);
        tick();

        // stall for 5 cycles on the second word
        go(5'd3, 8'd0);
        chk("t3_instr0", 32'(instr), 32'h00701);
        tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_valid", 32'(instr_valid), 32'd1);
            chk("t3_stall_instr", 32'(instr), 32'h00123);
            chk("t3_stall_pc",    32'(pc), 32'd1);
            tick();
        end
        instr_ready = 1'b1;
        chk("t3_resume_instr", 32'(instr), 32'h00123);
        tick();
        chk("t3_next_instr", 32'(instr), 32'h00ABC);
        chk("t3_next_pc",    32'(pc), 32'd2);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        tick();

        // zero-length program
        go(5'd0, 8'd5);
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_done",  32'(done), 32'd1);
        chk("t4_busy",  32'(busy), 32'd1);
        tick();
        chk("t4_done_end", 32'(done), 32'd0);
        chk("t4_busy_end", 32'(busy), 32'd0);

        // length above 16 saturates to 16
        go(5'd20, 8'd0);
        for (int k = 0; k < 16; k++) begin
            chk("t5_valid", 32'(instr_valid), 32'd1);
            chk("t5_pc",    32'(pc), 32'(k));
            tick();
        end
        chk("t5_done", 32'(done), 32'd1);
        tick();

        // write and start during ISSUE are dropped
        instr_ready = 1'b0;
        go(5'd2, 8'd0);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 18'h3FFFF;
        start = 1'b1; len = 5'd0;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("t6_hold_instr", 32'(instr), 32'h00701);
        chk("t6_hold_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        tick();
        chk("t6_instr1", 32'(instr), 32'h00123);
        tick();
        chk("t6_done", 32'(done), 32'd1);
        tick();
        instr_ready = 1'b0;
        go(5'd2, 8'd0);
        chk("t6_rerun_instr", 32'(instr), 32'h00701);

        // reset mid-run aborts without a done pulse
        rst_n = 1'b0;
        tick();
        chk("t7_valid", 32'(instr_valid), 32'd0);
        chk("t7_instr", 32'(instr), 32'd0);
        chk("t7_pc",    32'(pc), 32'd0);
        chk("t7_busy",  32'(busy), 32'd0);
        chk("t7_done",  32'(done), 32'd0);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("t7_post_done",  32'(done), 32'd0);
        chk("t7_post_busy",  32'(busy), 32'd0);
        chk("t7_post_valid", 32'(instr_valid), 32'd0);

        // program with a zero word in the middle
        wr(4'd0, 18'h00005);
        wr(4'd1, 18'h00000);
        wr(4'd2, 18'h00007);
        go(5'd3, 8'd0);
        chk("t8_valid0", 32'(instr_valid), 32'd1);
        chk("t8_instr0", 32'(instr), 32'h00005);
        tick();
        chk("t8_pc1", 32'(pc), 32'd1);
`ifdef MPU_ISSUE_NOP_SKIP_EN
        chk("t8_nop_valid", 32'(instr_valid), 32'd0);
`else
        chk("t8_zero_valid", 32'(instr_valid), 32'd1);
        chk("t8_zero_instr", 32'(instr), 32'd0);
`endif
        tick();
        chk("t8_valid2", 32'(instr_valid), 32'd1);
        chk("t8_instr2", 32'(instr), 32'h00007);
        chk("t8_pc2",    32'(pc), 32'd2);
        tick();
        chk("t8_done", 32'(done), 32'd1);
        tick();
        chk("t8_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
